// File: rtl/arm_instr_encoder.sv
// rtl/arm_instr_encoder.sv - symbolic request to ARM instruction word encoder and imem loader
//
// Purpose: encodes data-proc / memory / branch requests into 32-bit ARM words,
// buffers them in a DEPTH-word FIFO and writes them to instruction memory at
// consecutive byte addresses starting from BASE_ADDR.
//
// Optional feature macro: ENC_NOP_PAD_EN -- when defined, a flush appends
// PAD_COUNT MOV r0,r0 words after the FIFO drains.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   start, flush                control pulses (IDLE/DONE->RUN, RUN->FLUSH)
//   req_valid/req_ready         request handshake
//   req_kind..req_imm24         symbolic instruction fields
//   imem_stall                  memory busy, hold the current write
//   imem_we/addr/wdata          instruction-memory write port
//   word_count                  saturating count of words written since start
//   err_illegal                 sticky flag for accepted kind 11 requests
//   done                        high in DONE

module arm_instr_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                DEPTH     = 4,
   parameter int                PAD_COUNT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_kind,
   input  logic [3:0]        req_cond,
   input  logic [3:0]        req_opcode,
   input  logic              req_s,
   input  logic              req_imm,
   input  logic [3:0]        req_rn,
   input  logic [3:0]        req_rd,
   input  logic [11:0]       req_op2,
   input  logic [23:0]       req_imm24,
   input  logic              imem_stall,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [15:0]       word_count,
   output logic              err_illegal,
   output logic              done
);

   localparam int          PTR_W    = $clog2(DEPTH);
   localparam int          CNT_W    = PTR_W + 1;
   localparam logic [31:0] NOP_WORD = 32'hE1A00000;

`ifdef ENC_NOP_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t           state;
   logic [31:0]      fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_cnt;
   logic [15:0]      pad_cnt;

   logic        fifo_full;
   logic        fifo_empty;
   logic        active;
   logic        accept;
   logic        push;
   logic        pop;
   logic        pad_done;
   logic        pad_wr;
   logic        force_s;
   logic [31:0] enc_word;

   // TST/TEQ/CMP/CMN (opcodes 10xx) always set flags, so S is forced high.
   always_comb begin
      force_s  = (req_opcode[3:2] == 2'b10);
      enc_word = '0;
      case (req_kind)
         2'b00:   enc_word = {req_cond, 2'b00, req_imm, req_opcode, force_s | req_s,
                              req_rn, req_rd, req_op2};
         2'b01:   enc_word = {req_cond, 2'b01, 5'b01100, req_s, req_rn, req_rd, req_op2};
         default: enc_word = {req_cond, 3'b101, 1'b0, req_imm24};
      endcase
   end

   assign fifo_full  = (fifo_cnt == CNT_W'(DEPTH));
   assign fifo_empty = (fifo_cnt == '0);
   assign active     = (state == S_RUN) || (state == S_FLUSH);
   assign req_ready  = (state == S_RUN) && !fifo_full;
   assign accept     = req_valid && req_ready;
   // Illegal requests are consumed without occupying a FIFO slot.
   assign push       = accept && (req_kind != 2'b11);
   assign pop        = active && !fifo_empty && !imem_stall;

   // Padding only begins once every buffered word has been written.
   assign pad_done   = !PAD_EN || (pad_cnt == 16'(PAD_COUNT));
   assign pad_wr     = PAD_EN && (state == S_FLUSH) && fifo_empty && !pad_done && !imem_stall;

   assign imem_we    = pop | pad_wr;
   assign imem_wdata = pop ? fifo_mem[rd_ptr] : (pad_wr ? NOP_WORD : 32'h0);

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= enc_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_cnt    <= '0;
         pad_cnt     <= '0;
         imem_addr   <= BASE_ADDR;
         word_count  <= '0;
         err_illegal <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state       <= S_RUN;
                  wr_ptr      <= '0;
                  rd_ptr      <= '0;
                  fifo_cnt    <= '0;
                  imem_addr   <= BASE_ADDR;
                  word_count  <= '0;
                  err_illegal <= 1'b0;
                  done        <= 1'b0;
               end
            end
            S_RUN: begin
               if (flush) begin
                  state   <= S_FLUSH;
                  pad_cnt <= '0;
               end
            end
            S_FLUSH: begin
               if (fifo_empty && pad_done) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase

         // push/pop only occur in RUN/FLUSH, so they never collide with the
         // start-time clearing above.
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            fifo_cnt <= fifo_cnt + CNT_W'(1);
         end else if (!push && pop) begin
            fifo_cnt <= fifo_cnt - CNT_W'(1);
         end

         if (accept && (req_kind == 2'b11)) begin
            err_illegal <= 1'b1;
         end

         if (pad_wr) begin
            pad_cnt <= pad_cnt + 16'd1;
         end

         if (imem_we) begin
            imem_addr <= imem_addr + ADDR_W'(4);
            if (word_count != 16'hFFFF) begin
               word_count <= word_count + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_arm_instr_encoder.sv
// tb/tb_arm_instr_encoder.sv - scoreboard bench for arm_instr_encoder

module tb_arm_instr_encoder;

   localparam int          ADDR_W    = 32;
   localparam int          DEPTH     = 4;
   localparam int          PAD_COUNT = 3;
   localparam logic [31:0] BASE      = 32'h0;
   localparam logic [31:0] NOP       = 32'hE1A00000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              flush;
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_kind;
   logic [3:0]        req_cond;
   logic [3:0]        req_opcode;
   logic              req_s;
   logic              req_imm;
   logic [3:0]        req_rn;
   logic [3:0]        req_rd;
   logic [11:0]       req_op2;
   logic [23:0]       req_imm24;
   logic              imem_stall;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [15:0]       word_count;
   logic              err_illegal;
   logic              done;

   arm_instr_encoder #(
      .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH), .PAD_COUNT(PAD_COUNT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_cond(req_cond), .req_opcode(req_opcode), .req_s(req_s),
      .req_imm(req_imm), .req_rn(req_rn), .req_rd(req_rd), .req_op2(req_op2),
      .req_imm24(req_imm24), .imem_stall(imem_stall), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .word_count(word_count),
      .err_illegal(err_illegal), .done(done)
   );

   always #5 clk = ~clk;

   int          checks;
   int          errors;
   logic [63:0] exp_q[$];
   logic [31:0] next_addr;
   int          pushed;
   int          start_gen;
   bit          exp_err;
   bit          sim_done;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Field-level reference: each field is placed by its bit weight.
   function automatic logic [31:0] ref_encode(input int kind, input int cond, input int op,
                                              input int s, input int i, input int rn,
                                              input int rd, input int op2, input int imm24);
      longint w;
      int     sp;
      if (kind == 0) begin
         sp = (op >= 8 && op <= 11) ? 1 : s;
         w  = longint'(cond) * 268435456 + longint'(i) * 33554432 + longint'(op) * 2097152
            + longint'(sp) * 1048576 + longint'(rn) * 65536 + longint'(rd) * 4096 + op2;
      end else if (kind == 1) begin
         w  = longint'(cond) * 268435456 + 67108864 + 12 * 2097152
            + longint'(s) * 1048576 + longint'(rn) * 65536 + longint'(rd) * 4096 + op2;
      end else begin
         w  = longint'(cond) * 268435456 + 5 * 33554432 + imm24;
      end
      return w[31:0];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] word);
      exp_q.push_back({next_addr, word});
      next_addr = next_addr + 32'd4;
      pushed++;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start     = 1'b0;
      start_gen++;
      next_addr = BASE;
      pushed    = 0;
      exp_err   = 1'b0;
   endtask

   task automatic send(input int kind, input int cond, input int op, input int s, input int i,
                       input int rn, input int rd, input int op2, input int imm24,
                       input logic [31:0] exp_word, input bit rnd);
      bit acc = 1'b0;
      req_kind   = 2'(kind);
      req_cond   = 4'(cond);
      req_opcode = 4'(op);
      req_s      = 1'(s);
      req_imm    = 1'(i);
      req_rn     = 4'(rn);
      req_rd     = 4'(rd);
      req_op2    = 12'(op2);
      req_imm24  = 24'(imm24);
      req_valid  = 1'b1;
      for (int t = 0; t < 64 && !acc; t++) begin
         if (rnd) imem_stall = ($urandom_range(0, 3) == 0);
         #2;
         acc = req_ready;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL req_accept_timeout actual=0 required=1");
      end else if (kind == 3) begin
         exp_err = 1'b1;
      end else begin
         push_exp(exp_word);
      end
   endtask

   task automatic send_rand(input int kind, input bit rnd);
      int c, o, s, i, rn, rd, op2, imm;
      c = $urandom_range(0, 15);  o  = $urandom_range(0, 15);
      s = $urandom_range(0, 1);   i  = $urandom_range(0, 1);
      rn = $urandom_range(0, 15); rd = $urandom_range(0, 15);
      op2 = $urandom_range(0, 4095);
      imm = $urandom_range(0, 24'hFFFFFF);
      send(kind, c, o, s, i, rn, rd, op2, imm, ref_encode(kind, c, o, s, i, rn, rd, op2, imm), rnd);
   endtask

   task automatic drain(input string name, output int cycles);
      cycles = 0;
      while (exp_q.size() != 0 && cycles < 400) begin
         tick(1);
         cycles++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic monitor();
      int          mon_gen = 0;
      int          mon_cnt = 0;
      logic [63:0] e;
      while (!sim_done) begin
         @(negedge clk);
         if (rst_n && imem_we) begin
            if (mon_gen != start_gen) begin
               mon_gen = start_gen;
               mon_cnt = 0;
            end
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual=%0h@%0h required=none", imem_wdata, imem_addr);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", 64'(imem_addr), 64'(e[63:32]));
               check("write_data", 64'(imem_wdata), 64'(e[31:0]));
               check("word_count_live", 64'(word_count), 64'(mon_cnt));
            end
            mon_cnt++;
         end
      end
   endtask

   task automatic main_seq();
      int cyc;
      int k;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; req_valid = 1'b0; imem_stall = 1'b0;
      req_kind = '0; req_cond = '0; req_opcode = '0; req_s = 1'b0; req_imm = 1'b0;
      req_rn = '0; req_rd = '0; req_op2 = '0; req_imm24 = '0;
      tick(2);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_imem_we", 64'(imem_we), 64'd0);
      check("rst_imem_addr", 64'(imem_addr), 64'(BASE));
      check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
      check("rst_word_count", 64'(word_count), 64'd0);
      check("rst_err_illegal", 64'(err_illegal), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      tick(1);

      // Directed encodings from known-good instruction words.
      pulse_start();
      send(0, 14, 4, 0, 1, 2, 1, 12'h005, 0, 32'hE2821005, 1'b0);
      send(1, 14, 0, 1, 0, 1, 0, 12'h008, 0, 32'hE5910008, 1'b0);
      send(2, 14, 0, 0, 0, 0, 0, 0, 24'hFFFFFE, 32'hEAFFFFFE, 1'b0);
      send(0, 14, 10, 0, 0, 3, 0, 12'h004, 0, 32'hE1530004, 1'b0);
      drain("drain_directed", cyc);
      check("word_count_directed", 64'(word_count), 64'(pushed));

      // Backpressure: fill the FIFO under stall, then release for a burst.
      imem_stall = 1'b1;
      for (int n = 0; n < DEPTH; n++) send_rand($urandom_range(0, 2), 1'b0);
      #2;
      check("ready_when_full", 64'(req_ready), 64'd0);
      check("we_under_stall", 64'(imem_we), 64'd0);
      @(posedge clk);
      #1;
      imem_stall = 1'b0;
      drain("drain_burst", cyc);
      check("burst_cycles", 64'(cyc), 64'(DEPTH));

      // Illegal request sets the sticky flag and writes nothing.
      send_rand(3, 1'b0);
      check("err_after_illegal", 64'(err_illegal), 64'd1);
      send_rand(0, 1'b0);
      drain("drain_illegal", cyc);
      check("err_held", 64'(err_illegal), 64'd1);
      check("word_count_illegal", 64'(word_count), 64'(pushed));

      // Randomised traffic with random stalls.
      for (int n = 0; n < 300; n++) begin
         k = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         send_rand(k, 1'b1);
      end
      imem_stall = 1'b0;
      drain("drain_random", cyc);
      check("err_random", 64'(err_illegal), 64'(exp_err));
      check("word_count_random", 64'(word_count), 64'(pushed));

      // Flush with two words buffered; the second accepted on the flush edge.
      imem_stall = 1'b1;
      send_rand(1, 1'b0);
      flush = 1'b1;
      send_rand(2, 1'b0);
      flush = 1'b0;
`ifdef ENC_NOP_PAD_EN
      for (int n = 0; n < PAD_COUNT; n++) push_exp(NOP);
`endif
      check("done_before_drain", 64'(done), 64'd0);
      imem_stall = 1'b0;
      drain("drain_flush", cyc);
      cyc = 0;
      while (!done && cyc < 20) begin
         tick(1);
         cyc++;
      end
      check("done_after_flush", 64'(done), 64'd1);
      check("word_count_flush", 64'(word_count), 64'(pushed));
      check("ready_in_done", 64'(req_ready), 64'd0);

      // start from DONE reloads address, count and error flag.
      pulse_start();
      check("start_word_count", 64'(word_count), 64'd0);
      check("start_err", 64'(err_illegal), 64'd0);
      check("start_addr", 64'(imem_addr), 64'(BASE));
      check("start_done", 64'(done), 64'd0);

      // Reset mid-RUN discards buffered words.
      imem_stall = 1'b1;
      send_rand(0, 1'b0);
      send_rand(1, 1'b0);
      rst_n = 1'b0;
      tick(1);
      exp_q.delete();
      start_gen++;
      imem_stall = 1'b0;
      check("midrst_we", 64'(imem_we), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_ready", 64'(req_ready), 64'd0);
      check("midrst_word_count", 64'(word_count), 64'd0);
      rst_n = 1'b1;
      tick(3);
      pulse_start();
      send_rand(2, 1'b0);
      drain("drain_after_reset", cyc);
      check("word_count_after_reset", 64'(word_count), 64'd1);
      tick(2);
      check("queue_empty_end", 64'(exp_q.size()), 64'd0);
      sim_done = 1'b1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      next_addr = BASE;
      pushed    = 0;
      start_gen = 0;
      exp_err   = 1'b0;
      sim_done  = 1'b0;
      fork
         monitor();
         main_seq();
      join
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arm_instr_encoder.md
Name: arm_instr_encoder

Overview:
- Inverse of the ID-stage control decoder. Takes a stream of symbolic operation requests (kind, cond, opcode, S, registers, operand) and assembles 32-bit ARM instruction words in the format the decoder consumes.
- Buffers the words in a small FIFO and writes them sequentially into instruction memory.
- Used as the on-chip program loader and as the stimulus source for pipeline testbenches.

Parameters:
- ADDR_W, 32, instruction-memory byte-address width
- BASE_ADDR, 0, first write address after start
- DEPTH, 4, FIFO depth in words (power of 2, at least 2)
- PAD_COUNT, 3, NOP words appended on flush (only when ENC_NOP_PAD_EN is defined)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse: IDLE/DONE->RUN; reloads address and count
- flush  in  1  pulse: RUN->FLUSH
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_kind  in  2  00 data-proc, 01 memory, 10 branch, 11 illegal
- req_cond  in  4  condition field
- req_opcode  in  4  data-proc opcode
- req_s  in  1  S bit (data-proc) / L bit (memory: 1=LDR, 0=STR)
- req_imm  in  1  I bit (data-proc only)
- req_rn  in  4  Rn
- req_rd  in  4  Rd
- req_op2  in  12  shifter operand / offset
- req_imm24  in  24  branch offset
- imem_stall  in  1  memory busy; hold the current write
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  byte address
- imem_wdata  out  32  instruction word
- word_count  out  16  words written since start, saturating at 0xFFFF
- err_illegal  out  1  sticky; set on an accepted kind 11, cleared by start
- done  out  1  high in DONE

Behaviour:
- Clock and reset: single clock domain clk; rst_n is synchronous and active-low.
- Reset values: state IDLE, FIFO empty, req_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, word_count=0, err_illegal=0, done=0.
- States:
  - IDLE: on start -> RUN.
  - RUN: on flush -> FLUSH. start is ignored in RUN.
  - FLUSH: when the FIFO is empty (and padding is finished) -> DONE.
  - DONE: on start -> RUN.
- req_ready = (state==RUN) && !fifo_full. A flush in the same cycle as an accepted request still pushes that request.
- Encoding (combinational; pushed on the accept edge):
  - data-proc = {cond, 2'b00, I, opcode, S', Rn, Rd, op2}, where S'=1 when opcode is 1000/1001/1010/1011 (TST/TEQ/CMP/CMN), else req_s.
  - memory = {cond, 2'b01, 5'b01100, L, Rn, Rd, op2}.
  - branch = {cond, 3'b101, 1'b0, imm24}.
  - kind 11 is consumed, not pushed, and sets err_illegal.
- Write side:
  - When the FIFO is non-empty, state is RUN or FLUSH, and imem_stall=0: imem_we=1 for one cycle with the head word, the head is popped, imem_addr increments by 4 on the following edge, and word_count increments.
  - When imem_stall=1: imem_we=0, FIFO and address unchanged.
- Latency: a request accepted at edge N is presented on imem_we/imem_wdata in cycle N+1 if the FIFO was empty and there is no stall. Throughput is one word per cycle.
- Push and pop in the same cycle: occupancy is unchanged. Push is blocked when full.
- Address wraps modulo 2^ADDR_W.
- start reloads imem_addr=BASE_ADDR, word_count=0, err_illegal=0, and empties the FIFO.
- rst_n low mid-operation: all state returns to reset values on that edge and buffered words are discarded.

Optional Feature:
- Macro: ENC_NOP_PAD_EN.
- Defined: after the FIFO drains in FLUSH, the block writes PAD_COUNT words of 0xE1A00000 (MOV r0,r0) at consecutive addresses, honouring imem_stall, before entering DONE.
- Not defined: FLUSH goes to DONE as soon as the FIFO is empty.

Test Plan:
- Data-proc encode: start; ADD cond=E, I=1, S=0, Rn=2, Rd=1, op2=0x005 -> imem_wdata=0xE2821005 at addr 0, word_count=1.
- Forced S: CMP (opcode 1010) with S=0, Rn=3, Rd=0, op2=0x004 -> 0xE1530004.
- Memory and branch encode: LDR L=1, Rn=1, Rd=0, op2=8 -> 0xE5910008 at addr 4; branch cond=E, imm24=0xFFFFFE -> 0xEAFFFFFE at addr 8.
- Backpressure: hold imem_stall=1 and push DEPTH requests -> req_ready=0 after the 4th; release the stall -> 4 consecutive writes at addr +0,+4,+8,+12 in order.
- Illegal request: kind 11 -> no write, err_illegal=1 held until the next start; a subsequent valid request is still written at the next address.
- Flush and reset: flush with 2 words buffered -> both written, then done=1 (with ENC_NOP_PAD_EN: 3 extra 0xE1A00000 writes first); rst_n=0 mid-RUN -> imem_we=0, FIFO empty, done=0 next cycle.
